// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit signal bundle: instruction memory port, redirect input, instruction output
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, misalign_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, misalign_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with prefetch queue and single outstanding request
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   held_pc_q, held_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_pc_d    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];

    logic          misalign;
    logic [31:0]   redirect_pc_eff;
    logic          rvalid_live;
    logic [CW-1:0] slots_used;
    logic          req;
    logic          accept;
    logic          push;
    logic          pop;
    logic          instr_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misalign        = misalign_q;
    assign redirect_pc_eff = bus.redirect_pc_i;

    always_comb begin
        misalign_d = misalign_q;
        if (bus.redirect_i) begin
            misalign_d = |bus.redirect_pc_i[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign misalign        = 1'b0;
    assign redirect_pc_eff = bus.redirect_pc_i & 32'hFFFF_FFFC;
`endif

    // A response counts against the queue from grant onward, so a queued slot is always free for it.
    assign rvalid_live = outstanding_q && bus.imem_rvalid_i;
    assign slots_used  = count_q + {{AW{1'b0}}, outstanding_q};
    assign req         = (!outstanding_q || bus.imem_rvalid_i) && (slots_used < DEPTH_C)
                         && !bus.redirect_i && !misalign;
    assign accept      = req && bus.imem_gnt_i;
    assign push        = rvalid_live && !drop_q && !bus.redirect_i;
    assign instr_valid = (count_q != '0) && !bus.redirect_i;
    assign pop         = instr_valid && bus.instr_ready_i;

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = q_instr_q[rd_ptr_q];
    assign bus.pc_o          = q_pc_q[rd_ptr_q];
    assign bus.misalign_o    = misalign;

    always_comb begin
        pc_d          = pc_q;
        held_pc_d     = held_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;

        if (push) begin
            q_pc_d[wr_ptr_q]    = held_pc_q;
            q_instr_d[wr_ptr_q] = bus.imem_rdata_i;
        end

        if (bus.redirect_i) begin
            // A response arriving this very cycle is discarded here; otherwise mark the next one stale.
            pc_d          = redirect_pc_eff;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            outstanding_d = outstanding_q && !bus.imem_rvalid_i;
            drop_d        = outstanding_q && !bus.imem_rvalid_i;
        end else begin
            if (accept) begin
                pc_d          = pc_q + 32'd4;
                held_pc_d     = pc_q;
                outstanding_d = 1'b1;
            end else if (rvalid_live) begin
                outstanding_d = 1'b0;
            end
            if (rvalid_live) begin
                drop_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            held_pc_q     <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            held_pc_q     <= held_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2): prefetch queue entries.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1: synchronous, active-high reset.
REQ-005 Port imem_req_o  out  1 / imem_addr_o  out  32: fetch request and word address.
REQ-006 Port imem_gnt_i  in  1: memory accepts the request this cycle.
REQ-007 Port imem_rvalid_i  in  1 / imem_rdata_i  in  32: read response, at least 1 cycle after grant.
REQ-008 Port redirect_i  in  1 / redirect_pc_i  in  32: branch, jump or jalr target from execute.
REQ-009 Port instr_valid_o  out  1 / instr_o  out  32 / pc_o  out  32: queue head instruction and its PC.
REQ-010 Port instr_ready_i  in  1: consumer takes the head this cycle.
REQ-011 Port misalign_o  out  1: sticky misaligned-redirect flag.

Function
REQ-012 Fetch PC register increments by 4 on each accepted request (imem_req_o && imem_gnt_i); modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-013 imem_addr_o equals the fetch PC; the accepted address is held with the outstanding request.
REQ-014 At most one outstanding request: imem_req_o = (!outstanding || imem_rvalid_i) && (count + outstanding < DEPTH) && !redirect_i && !misalign_o.
REQ-015 imem_req_o remains high with a stable imem_addr_o until granted.
REQ-016 A response that is not marked for drop pushes {held PC, imem_rdata_i} into the queue at the next edge.
REQ-017 imem_rvalid_i with no outstanding request is ignored.
REQ-018 instr_valid_o = (count != 0) && !redirect_i; instr_o and pc_o come from the queue head; pop on instr_valid_o && instr_ready_i.
REQ-019 Push and pop in the same cycle leave count unchanged and are legal when full; REQ-014 reserves the slot.
REQ-020 Latency: with rvalid one cycle after grant and an empty queue, instr_valid_o rises 2 cycles after the grant.
REQ-021 Redirect has priority over every other event. It flushes the queue (count to 0), ignores any pop, loads the fetch PC with redirect_pc_i, and suppresses imem_req_o that cycle.
REQ-022 Redirect while a request is outstanding and imem_rvalid_i is low sets the drop flag. The next response is discarded, the flag clears, and a new request can issue in that same response cycle.
REQ-023 Redirect in the same cycle as imem_rvalid_i discards that response and does not set the drop flag.
REQ-024 Repeated redirects before the dropped response arrives keep exactly one pending drop; the last redirect_pc_i wins.

Reset
REQ-025 On rst: fetch PC = RESET_PC, count = 0, queue pointers = 0, outstanding = 0, drop flag = 0, misalign_o = 0.
REQ-026 In the cycle after reset, instr_valid_o = 0 and imem_req_o = 1 with imem_addr_o = RESET_PC.
REQ-027 Reset mid-transaction abandons the in-flight request; its late response is ignored per REQ-017.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN, when defined: a redirect with redirect_pc_i[1:0] != 0 sets misalign_o at the next edge, still flushes the queue, and stops requests. The flag clears only on rst or an aligned redirect.
REQ-029 When FETCH_MISALIGN_TRAP_EN is undefined: redirect_pc_i[1:0] is treated as 2'b00 and misalign_o is tied to 0.

Verification
REQ-030 Streaming: memory grants every cycle with 1-cycle rvalid, instr_ready_i=1 -> pc_o sequence 0,4,8,... at 1 instr/cycle after the initial 2-cycle latency.
REQ-031 Backpressure: instr_ready_i=0 for 10 cycles -> exactly 4 entries queued, imem_req_o low, no response lost; release -> PCs continue in order.
REQ-032 Redirect in flight: redirect to 32'h0000_0100 while 32'h0000_0010 is outstanding, rvalid arrives 3 cycles later -> that data is discarded; next pc_o = 32'h100.
REQ-033 Wrap: redirect to 32'hFFFF_FFF8 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 Misalign (macro defined): redirect to 32'h0000_0102 -> misalign_o=1 next cycle and no requests; redirect to 32'h200 clears it. Macro undefined: same redirect fetches 32'h100.
REQ-035 Reset mid-run: rst asserted with 3 entries queued and 1 request outstanding -> next cycle count=0 and imem_addr_o=RESET_PC; the stale rvalid is ignored.
